// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and default widths for the ALU arbiter
package alu_pkg;
  localparam int DEF_OP_W  = 4;
  localparam int DEF_RES_W = 20;
  typedef enum logic [1:0] {ADD, SUB, SHL, SHR} opcode_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_arbiter_mini_alu.sv
// alu_arbiter_mini_alu: add/sub/shift unit shared by the arbiter requesters
// Ports: op1_i/op2_i operands, op_i 0=add/sub 1=shift, sign_i 0=add/left 1=sub/right, result_o
module alu_arbiter_mini_alu #(
  parameter int OP_W  = 4,
  parameter int RES_W = 20
) (
  input  logic [OP_W-1:0]  op1_i,
  input  logic [OP_W-1:0]  op2_i,
  input  logic             op_i,
  input  logic             sign_i,
  output logic [RES_W-1:0] result_o
);
  logic [RES_W-1:0] a, b;
  assign a = RES_W'(op1_i);
  assign b = RES_W'(op2_i);
  assign result_o = op_i ? (sign_i ? a >> op2_i : a << op2_i) : (sign_i ? a - b : a + b);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one miniALU among NUM_REQ valid/ready requesters
// Ports: clk, rst (async high); req_valid/req_ready/req_op1/req_op2/req_opcode request side;
//        rsp_valid/rsp_ready/rsp_result response side; busy (not IDLE); ops_done handshake count
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = DEF_OP_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_op1,
  input  logic [NUM_REQ*OP_W-1:0] req_op2,
  input  logic [NUM_REQ*2-1:0]    req_opcode,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [RES_W-1:0]        rsp_result,
  output logic                    busy,
  output logic [CNT_W-1:0]        ops_done
);
  localparam int GW = $clog2(NUM_REQ);
  // first requesting index at or above ptr, wrapping; lowest offset wins
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [GW-1:0] ptr);
    logic [GW-1:0] p;
    p = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (v[(int'(ptr) + k) % NUM_REQ]) p = GW'((int'(ptr) + k) % NUM_REQ);
    return p;
  endfunction
  state_e            state_q, state_d;
  opcode_e           opc_q, opc_d;
  logic [OP_W-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [GW-1:0]     gnt_q, gnt_d, rr_q, rr_d, pick;
  logic [RES_W-1:0]  res_q, res_d, alu_res;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hs;
  assign hs         = state_q == RESP && rsp_ready[gnt_q];
  assign rsp_valid  = state_q == RESP ? NUM_REQ'(1) << gnt_q : '0;
  assign rsp_result = res_q;
  assign busy       = state_q != IDLE;
  assign ops_done   = cnt_q;
  // opcode encoding lines up with the ALU controls: bit1 selects shift, bit0 selects sub/right
  alu_arbiter_mini_alu #(.OP_W(OP_W), .RES_W(RES_W)) u_alu (
    .op1_i(op1_q), .op2_i(op2_q), .op_i(opc_q[1]), .sign_i(opc_q[0]), .result_o(alu_res)
  );
  always_comb begin
    pick      = rr_pick(req_valid, rr_q);
    state_d   = state_q;
    opc_d     = opc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    if (state_q == IDLE && |req_valid) begin
      req_ready = NUM_REQ'(1) << pick;
      op1_d     = req_op1[pick*OP_W +: OP_W];
      op2_d     = req_op2[pick*OP_W +: OP_W];
      opc_d     = opcode_e'(req_opcode[pick*2 +: 2]);
      gnt_d     = pick;
      state_d   = EXEC;
    end
    if (state_q == EXEC) begin
      res_d   = alu_res;
      state_d = RESP;
    end
    if (hs) begin
      cnt_d   = cnt_q + 1'b1;
      rr_d    = gnt_q == GW'(NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      opc_q   <= ADD;
      op1_q   <= '0;
      op2_q   <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  localparam int N = 2, OW = 4, RW = 20, CW = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*OW-1:0] req_op1 = '0, req_op2 = '0;
  logic [N*2-1:0] req_opcode = '0;
  logic [RW-1:0] rsp_result;
  logic busy;
  logic [CW-1:0] ops_done;
  int errors = 0, checks = 0, last = N - 1, cnt = 0;
  logic [N-1:0] seen;

  alu_arbiter #(.NUM_REQ(N), .OP_W(OW), .RES_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op1(req_op1),
    .req_op2(req_op2), .req_opcode(req_opcode), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_res(int opc, int a, int b);
    case (opc)
      0: return (a + b) % (1 << RW);
      1: return (a - b + (1 << RW)) % (1 << RW);
      2: return (a << b) % (1 << RW);
      default: return a >> b;
    endcase
  endfunction

  function automatic int rr_next(logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic set_req(int i, int opc, int a, int b);
    req_opcode[i*2 +: 2] = 2'(opc);
    req_op1[i*OW +: OW] = OW'(a);
    req_op2[i*OW +: OW] = OW'(b);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic transact(input logic [N-1:0] v, input int hold, input bit keep, output logic [N-1:0] got_ready);
    int g, exp;
    req_valid = v;
    g = rr_next(v);
    exp = ref_res(int'(req_opcode[g*2 +: 2]), int'(req_op1[g*OW +: OW]), int'(req_op2[g*OW +: OW]));
    #1 got_ready = req_ready;
    chk("accept_ready", req_ready, 1 << g);
    chk("accept_busy", busy, 0);
    @(negedge clk);
    if (!keep) req_valid = '0;
    rand_ops();
    #1 chk("exec_ready", req_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rsp_ready = hold > 0 ? N'($urandom) & ~N'(1 << g) : '1;
    #1 chk("rsp_valid", rsp_valid, 1 << g);
    chk("rsp_result", rsp_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1 chk("hold_valid", rsp_valid, 1 << g);
      chk("hold_result", rsp_result, exp);
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
      rsp_ready = i == hold - 1 ? '1 : N'($urandom) & ~N'(1 << g);
    end
    @(negedge clk);
    rsp_ready = '0;
    cnt = (cnt + 1) % (1 << CW);
    last = g;
    #1 chk("done_valid", rsp_valid, 0);
    chk("ops_done", ops_done, cnt);
  endtask

  task automatic do_reset();
    rst = 1;
    req_valid = '0;
    rsp_ready = '0;
    #1 chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    last = N - 1;
    cnt = 0;
  endtask

  initial begin
    do_reset();
    set_req(0, 0, 10, 10);
    rsp_ready = '1;
    transact(2'b01, 0, 0, seen);
    chk("single_result", rsp_result, 20);
    set_req(0, 0, 3, 4);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rsp_ready = '0;
    #1 chk("pre_rst_valid", rsp_valid, 1);
    #2 rst = 1;
    #1 chk("async_valid", rsp_valid, 0);
    chk("async_result", rsp_result, 0);
    chk("async_busy", busy, 0);
    chk("async_ops", ops_done, 0);
    @(negedge clk);
    rst = 0;
    last = N - 1;
    cnt = 0;
    rsp_ready = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ready", req_ready, 0);
    end
    rsp_ready = '0;
    set_req(1, 1, 10, 9);
    transact(2'b10, 0, 0, seen);
    chk("sub_result", rsp_result, 1);
    set_req(1, 2, 10, 10);
    transact(2'b10, 0, 0, seen);
    chk("shl_result", rsp_result, 10240);
    set_req(1, 3, 10, 1);
    transact(2'b10, 0, 0, seen);
    chk("shr_result", rsp_result, 5);
    chk("ops_three", ops_done, 3);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      transact(2'b11, 0, 1, seen);
      chk("alternate", seen, 1 << (i % 2));
    end
    set_req(0, 1, 7, 9);
    transact(2'b01, 5, 0, seen);
    rand_ops();
    transact(2'b11, 0, 0, seen);
    chk("next_grant", seen, 2'b10);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      transact(N'($urandom_range(1, 3)), 0, $urandom_range(0, 1), seen);
    end
    chk("wrap", ops_done, 0);
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(0, 3));
      rand_ops();
      if (v == 0) begin
        req_valid = '0;
        #1 chk("idle_ready", req_ready, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk);
      end else transact(v, $urandom_range(0, 3), $urandom_range(0, 1), seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
